// File: rtl/pattern_gen.sv
// Run-based stream stimulus source: emits runs of repeated values over valid/ready.
// Optional PATTERN_GEN_LFSR_EN replaces the additive run step with a Galois LFSR step.
module pattern_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_base,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [LEN_W-1:0] cfg_run_len,
  input  logic [CNT_W-1:0] cfg_num_runs,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] run_idx,
  output logic [LEN_W-1:0] beat_idx
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

`ifdef PATTERN_GEN_LFSR_EN
  // Maximal-length Galois taps per width (shift right, XOR taps when LSB was 1)
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      2:       return 32'h3;
      3:       return 32'h6;
      4:       return 32'hC;
      5:       return 32'h14;
      6:       return 32'h30;
      7:       return 32'h60;
      8:       return 32'hB8;
      16:      return 32'hB400;
      default: return 32'hC;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  function automatic logic [WIDTH-1:0] run_next(input logic [WIDTH-1:0] d);
    return (d >> 1) ^ (d[0] ? TAPS : '0);
  endfunction
`else
  logic [WIDTH-1:0] step_q, step_nxt;
`endif

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [CNT_W-1:0] num_q, num_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [CNT_W-1:0] run_nxt;
  logic [LEN_W-1:0] beat_nxt;
  logic             valid_nxt, busy_nxt, done_nxt;
  logic             xfer, last_beat, last_run;

  assign xfer      = valid & ready;
  assign last_beat = (beat_idx == len_q - LEN_W'(1));
  assign last_run  = (num_q != '0) && (run_idx == num_q - CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      len_q    <= '0;
      num_q    <= '0;
      data     <= '0;
      run_idx  <= '0;
      beat_idx <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifndef PATTERN_GEN_LFSR_EN
      step_q   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      len_q    <= len_nxt;
      num_q    <= num_nxt;
      data     <= data_nxt;
      run_idx  <= run_nxt;
      beat_idx <= beat_nxt;
      valid    <= valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
`ifndef PATTERN_GEN_LFSR_EN
      step_q   <= step_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    num_nxt   = num_q;
    data_nxt  = data;
    run_nxt   = run_idx;
    beat_nxt  = beat_idx;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
`ifndef PATTERN_GEN_LFSR_EN
    step_nxt  = step_q;
`endif

    case (state)
      IDLE: begin
        if (start && !abort) begin
          len_nxt   = (cfg_run_len == '0) ? LEN_W'(1) : cfg_run_len;
          num_nxt   = cfg_num_runs;
          run_nxt   = '0;
          beat_nxt  = '0;
          state_nxt = EMIT;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
`ifdef PATTERN_GEN_LFSR_EN
          data_nxt  = (cfg_base == '0) ? WIDTH'(1) : cfg_base;
`else
          data_nxt  = cfg_base;
          step_nxt  = cfg_step;
`endif
        end
      end

      EMIT: begin
        // A beat taken in the abort cycle still advances the indices
        if (xfer) begin
          if (!last_beat) begin
            beat_nxt = beat_idx + LEN_W'(1);
          end else if (last_run) begin
            state_nxt = DONE;
          end else begin
            beat_nxt = '0;
            run_nxt  = run_idx + CNT_W'(1);
`ifdef PATTERN_GEN_LFSR_EN
            data_nxt = run_next(data);
`else
            data_nxt = data + step_q;
`endif
          end
        end
        if (abort) state_nxt = IDLE;
        valid_nxt = (state_nxt == EMIT);
        busy_nxt  = (state_nxt == EMIT);
        done_nxt  = (state_nxt == DONE);
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: config table plus hand sequences, transfers checked against a queue.
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] cfg_base = '0;
  logic [3:0] cfg_step = '0;
  logic [3:0] cfg_run_len = '0;
  logic [7:0] cfg_num_runs = '0;
  logic [3:0] data;
  logic       valid, busy, done;
  logic [7:0] run_idx;
  logic [3:0] beat_idx;

  always #5 clk = ~clk;

  pattern_gen #(.WIDTH(4), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_step(cfg_step), .cfg_run_len(cfg_run_len),
    .cfg_num_runs(cfg_num_runs), .ready(ready), .data(data), .valid(valid),
    .busy(busy), .done(done), .run_idx(run_idx), .beat_idx(beat_idx)
  );

  typedef struct {
    logic [3:0] data;
    logic [7:0] run;
    logic [3:0] beat;
  } exp_t;

  typedef struct {
    logic [3:0] base;
    logic [3:0] step;
    logic [3:0] len;
    logic [7:0] num;
    logic       rnd;
    int         exp_beats;
    logic [3:0] exp_last;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_xfer = -10, done_cnt = 0, xfer_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mnext(input logic [3:0] d, input logic [3:0] s);
`ifdef PATTERN_GEN_LFSR_EN
    return d[0] ? ((d >> 1) ^ 4'hC) : (d >> 1);
`else
    return d + s;
`endif
  endfunction

  // Expected beat sequence; nbeats>0 caps the list (needed for free-running configs)
  task automatic model_push(input logic [3:0] base, input logic [3:0] step,
                            input logic [3:0] len, input logic [7:0] num, input int nbeats);
    int L, total, r, b;
    logic [3:0] d;
    exp_t e;
    L = (len == 0) ? 1 : int'(len);
    total = (nbeats > 0) ? nbeats : int'(num) * L;
    d = base;
`ifdef PATTERN_GEN_LFSR_EN
    if (d == 4'h0) d = 4'h1;
`endif
    r = 0;
    b = 0;
    for (int k = 0; k < total; k++) begin
      e.data = d;
      e.run  = 8'(r);
      e.beat = 4'(b);
      sb.push_back(e);
      b++;
      if (b == L) begin
        b = 0;
        r++;
        d = mnext(d, step);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset_n && valid && ready) begin
      xfer_cnt++;
      last_xfer = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_xfer", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("xfer_data", data, e.data);
        chk("xfer_run_idx", run_idx, e.run);
        chk("xfer_beat_idx", beat_idx, e.beat);
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_gap", cyc - last_xfer, 1);
      chk("done_valid_low", valid, 0);
      chk("done_busy_low", busy, 0);
    end
  end

  // Pulse start; leaves the bench #1 into the first EMIT cycle with cfg scrambled
  task automatic start_cfg(input logic [3:0] base, input logic [3:0] step,
                           input logic [3:0] len, input logic [7:0] num, input int nbeats);
    sb.delete();
    model_push(base, step, len, num, nbeats);
    done_cnt = 0;
    xfer_cnt = 0;
    @(posedge clk); #1;
    cfg_base = base; cfg_step = step; cfg_run_len = len; cfg_num_runs = num;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_base = 4'($urandom); cfg_step = 4'($urandom);
    cfg_run_len = 4'($urandom); cfg_num_runs = 8'($urandom);
    chk("first_valid", valid, 1);
    chk("first_busy", busy, 1);
    chk("first_data", data, sb[0].data);
    chk("first_run_idx", run_idx, 0);
    chk("first_beat_idx", beat_idx, 0);
  endtask

  task automatic wait_done(input int budget, input logic rnd, input logic poke);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && (i == 1);
      @(posedge clk); #1;
      i++;
    end
    start = 1'b0;
    ready = 1'b1;
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    chk("valid_after_done", valid, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int pat[11];
    pat = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[0] = '{4'h3, 4'h1, 4'd2,  8'd3, 1'b0, 6,  4'h5};
    tbl[1] = '{4'hF, 4'h1, 4'd0,  8'd3, 1'b0, 3,  4'h1};
    tbl[2] = '{4'h5, 4'h0, 4'd3,  8'd2, 1'b1, 6,  4'h5};
    tbl[3] = '{4'hA, 4'h3, 4'd1,  8'd5, 1'b1, 5,  4'h6};
    tbl[4] = '{4'h2, 4'h7, 4'd15, 8'd2, 1'b1, 30, 4'h9};
    tbl[5] = '{4'hC, 4'h9, 4'd4,  8'd3, 1'b0, 12, 4'hE};

    #12;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", data, 0);
    chk("rst_run_idx", run_idx, 0);
    chk("rst_beat_idx", beat_idx, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ready = 1'b1;

    for (int t = 0; t < 6; t++) begin
      start_cfg(tbl[t].base, tbl[t].step, tbl[t].len, tbl[t].num, 0);
      wait_done(500, tbl[t].rnd, 1'b1);
      chk("tbl_beats", xfer_cnt, tbl[t].exp_beats);
      chk("tbl_sb_empty", sb.size(), 0);
`ifndef PATTERN_GEN_LFSR_EN
      chk("tbl_last_data", data, tbl[t].exp_last);
`endif
      chk("tbl_hold_run", run_idx, tbl[t].num - 8'd1);
      chk("tbl_hold_beat", beat_idx, (tbl[t].len == 0) ? 4'd0 : tbl[t].len - 4'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("tbl_done_once", done_cnt, 1);
      chk("tbl_idle_valid", valid, 0);
    end

    // Backpressure: stalls before beats 2 and 3 must hold the beat on the bus
    start_cfg(4'h7, 4'h2, 4'd3, 8'd1, 0);
    for (int i = 0; i < 11; i++) begin
      ready = 1'(pat[i]);
      @(negedge clk);
      if (pat[i] == 0) begin
        chk("stall_valid", valid, 1);
        chk("stall_data", data, 4'h7);
      end
      @(posedge clk); #1;
    end
    wait_done(20, 1'b0, 1'b0);
    chk("bp_xfers", xfer_cnt, 3);
    chk("bp_done_once", done_cnt, 1);

    // Abort together with start on the 6th beat of a free-running stream
    ready = 1'b1;
    start_cfg(4'h0, 4'h5, 4'd4, 8'd0, 6);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sb_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle_valid", valid, 0);
    start_cfg(4'h0, 4'h5, 4'd4, 8'd1, 0);
    wait_done(50, 1'b0, 1'b0);
    chk("restart_done_once", done_cnt, 1);

    // Asynchronous reset between clock edges mid-stream
    start_cfg(4'h2, 4'h3, 4'd4, 8'd0, 40);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset_valid", valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_data", data, 0);
    chk("areset_run_idx", run_idx, 0);
    chk("areset_beat_idx", beat_idx, 0);
    sb.delete();
    @(posedge clk); #3;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("areset_no_done", done_cnt, 0);
    chk("areset_idle_valid", valid, 0);

`ifdef PATTERN_GEN_LFSR_EN
    start_cfg(4'h0, 4'h0, 4'd1, 8'd4, 0);
    wait_done(50, 1'b0, 1'b0);
    chk("lfsr_beats", xfer_cnt, 4);
    chk("lfsr_last", data, 4'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Stimulus source for the stream pattern detector: emits a WIDTH-bit data stream built from runs of repeated values.
- Each run is one value held for a programmable number of beats. Successive runs step by a programmable increment.
- Sits upstream of the detector's data input. Produces known streak lengths and known value transitions for sum/product checking.
- Uses a valid/ready handshake so a consumer can stall the stream.

Parameters:
- WIDTH, 4, data width; matches the detector data width.
- LEN_W, 4, width of run-length config and beat counter.
- CNT_W, 8, width of run-count config and run counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; latches config and begins emission
- abort  in  1  stops emission immediately; no done pulse
- cfg_base  in  WIDTH  value of the first run
- cfg_step  in  WIDTH  increment between runs, mod 2^WIDTH
- cfg_run_len  in  LEN_W  beats per run; 0 is treated as 1
- cfg_num_runs  in  CNT_W  number of runs; 0 means free-running until abort
- ready  in  1  consumer accepts data this cycle
- data  out  WIDTH  current stream value
- valid  out  1  data is valid
- busy  out  1  high in EMIT
- done  out  1  one-cycle pulse after the last beat of the last run
- run_idx  out  CNT_W  index of the current run
- beat_idx  out  LEN_W  beat within the current run

Behaviour:
- Interface: one clock clk; reset_n is asynchronous, active-low.
- Reset: state=IDLE; data=0, valid=0, busy=0, done=0, run_idx=0, beat_idx=0; latched config cleared.
- States: IDLE, EMIT, DONE.
- IDLE: start=1 and abort=0 → latch cfg_*, data<=cfg_base, run_idx<=0, beat_idx<=0, go to EMIT.
  - valid rises the cycle after start; latency start→first valid is 1 cycle.
- EMIT:
  - valid=1, busy=1.
  - A transfer is valid&&ready. data, run_idx and beat_idx change only on a transfer; with ready=0 they hold stable for any number of cycles.
- On a transfer, with L = latched run length (0→1):
  - beat_idx < L-1: beat_idx++ and data unchanged.
  - beat_idx == L-1, and this is not the last run: beat_idx<=0, run_idx++, data<=data+step (mod 2^WIDTH).
  - Last run means num_runs!=0 and run_idx==num_runs-1. Last beat of last run → go to DONE; valid=0 next cycle.
  - num_runs==0: run_idx wraps from 2^CNT_W-1 to 0; emission continues.
- DONE: lasts one cycle with done=1, valid=0, busy=0, then returns to IDLE.
  - data keeps its last transferred value.
  - run_idx/beat_idx hold until the next start.
- abort:
  - In EMIT: next state IDLE, valid=0 the next cycle, no done pulse. A transfer in the abort cycle still counts (the consumer took it).
  - Abort has priority over start in the same cycle.
  - Abort in IDLE or DONE has no effect, except that DONE still returns to IDLE.
- start during EMIT or DONE is ignored. cfg_* changes outside the start cycle have no effect.
- Config edge cases:
  - cfg_step=0: one continuous run of constant value, so the downstream streak grows across run boundaries.
  - L=1: every beat is a new run.
- Reset asserted mid-EMIT: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: PATTERN_GEN_LFSR_EN.
- Defined:
  - Run-to-run update is a Galois LFSR step on data, with a fixed maximal-length polynomial per WIDTH (WIDTH=4: x^4+x^3+1, i.e. shift right, XOR 4'hC when the LSB was 1).
  - cfg_step is ignored.
  - A latched cfg_base of 0 is replaced by 1 to avoid lock-up.
- Not defined: additive step as above; the LFSR logic is absent.

Test Plan:
- Basic runs: cfg_base=3, step=1, run_len=2, num_runs=3, ready=1, start pulse → data 3,3,4,4,5,5 on six consecutive valid cycles, beat_idx 0,1,0,1,0,1, done pulse the cycle after the 6th beat, valid low after.
- Backpressure: base=7, step=2, run_len=3, num_runs=1; ready low on beats 2 and 3 for 4 cycles each → data held at 7 with valid=1 throughout stalls, exactly 3 transfers of 7, done once.
- Wrap and zero length: base=4'hF, step=1, run_len=0, num_runs=3 → data F,0,1, one beat each, done pulse.
- Abort and start priority: free-running (num_runs=0), base=0, step=5, run_len=4; assert abort and start together at beat 6 → valid=0 next cycle, state IDLE, no done; a later start restarts at run_idx=0, data=0.
- Async reset mid-run: reset_n low between clock edges during EMIT → valid, busy, data, run_idx, beat_idx all 0 without waiting for a clk edge.
- LFSR (PATTERN_GEN_LFSR_EN): base=0, run_len=1, num_runs=4 → data 1,C,6,3.
